// File: rtl/tx_frame_pkg.sv
// Shared types and constants for the TX frame serializer.
// TX_FRAME_CRC8_EN adds the CRC state to the state enum.
package tx_frame_pkg;

    localparam int unsigned BYTE_W             = 8;
    localparam int unsigned DEF_PREAMBLE_BYTES = 4;
    localparam logic [7:0]  DEF_PREAMBLE_BYTE  = 8'h55;
    localparam logic [7:0]  DEF_SFD_BYTE       = 8'hD5;
    localparam logic [7:0]  CRC8_POLY          = 8'h07;

`ifdef TX_FRAME_CRC8_EN
    typedef enum logic [2:0] {S_IDLE, S_PRE, S_SFD, S_LEN, S_PAY, S_CRC} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_PRE, S_SFD, S_LEN, S_PAY} state_t;
`endif

    // MSB-first CRC-8 update over one byte; no reflection, no final XOR.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? (8'(c << 1) ^ CRC8_POLY) : 8'(c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/tx_frame_serializer_dibit_shifter.sv
// 8-bit MSB-first dibit shifter with a 2-bit dibit counter.
// last_c flags the strobe that emits the final dibit of the current byte.
module tx_frame_serializer_dibit_shifter
    import tx_frame_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              sym_en,
    input  logic              active,
    input  logic              load,
    input  logic [BYTE_W-1:0] load_byte,
    output logic [1:0]        dibit_c,
    output logic              last_c
);

    logic [BYTE_W-1:0] sh_q;
    logic [1:0]        cnt_q;

    // A load (start or byte boundary) overrides the shift and restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else if (load) begin
            sh_q  <= load_byte;
            cnt_q <= '0;
        end else if (sym_en && active) begin
            sh_q  <= {sh_q[BYTE_W-3:0], 2'b00};
            cnt_q <= cnt_q + 2'd1;
        end
    end

    assign dibit_c = sh_q[BYTE_W-1:BYTE_W-2];
    assign last_c  = sym_en && active && (cnt_q == 2'd3);

endmodule

// File: rtl/tx_frame_serializer.sv
// Frame builder: preamble, SFD, length, payload (+ CRC-8 when
// TX_FRAME_CRC8_EN is defined) serialized as MSB-first dibits.
module tx_frame_serializer
    import tx_frame_pkg::*;
#(
    parameter int unsigned PREAMBLE_BYTES = DEF_PREAMBLE_BYTES,
    parameter logic [7:0]  PREAMBLE_BYTE  = DEF_PREAMBLE_BYTE,
    parameter logic [7:0]  SFD_BYTE       = DEF_SFD_BYTE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sym_en,
    input  logic       start,
    input  logic [7:0] tx_len,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic [1:0] to_lvds,
    output logic       busy,
    output logic       done,
    output logic       underrun
);

    localparam int unsigned PRE_CNT_W = 4;

    state_t                 state_q, state_d;
    logic [BYTE_W-1:0]      len_q, len_d;
    logic [PRE_CNT_W-1:0]   pre_cnt_q, pre_cnt_d;
    logic [BYTE_W-1:0]      pay_cnt_q, pay_cnt_d;
    logic                   underrun_d;
    logic                   done_d;
    logic                   load;
    logic [BYTE_W-1:0]      load_byte;
    logic [1:0]             dibit_c;
    logic                   last_c;
    logic                   active;
`ifdef TX_FRAME_CRC8_EN
    logic [BYTE_W-1:0]      crc_q, crc_d;
`endif

    assign active = (state_q != S_IDLE);

    tx_frame_serializer_dibit_shifter u_shifter (
        .clk       (clk),
        .reset     (reset),
        .sym_en    (sym_en),
        .active    (active),
        .load      (load),
        .load_byte (load_byte),
        .dibit_c   (dibit_c),
        .last_c    (last_c)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state, byte selection at each boundary, and payload pop.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        pre_cnt_d  = pre_cnt_q;
        pay_cnt_d  = pay_cnt_q;
        underrun_d = underrun;
        done_d     = 1'b0;
        load       = 1'b0;
        load_byte  = '0;
        byte_ready = 1'b0;
`ifdef TX_FRAME_CRC8_EN
        crc_d      = crc_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start && (tx_len != 8'd0)) begin
                    state_d    = S_PRE;
                    len_d      = tx_len;
                    underrun_d = 1'b0;
                    load       = 1'b1;
                    load_byte  = PREAMBLE_BYTE;
                    pre_cnt_d  = '0;
`ifdef TX_FRAME_CRC8_EN
                    crc_d      = '0;
`endif
                end
            end
            S_PRE: begin
                if (last_c) begin
                    load = 1'b1;
                    if (pre_cnt_q == PRE_CNT_W'(PREAMBLE_BYTES - 1)) begin
                        load_byte = SFD_BYTE;
                        state_d   = S_SFD;
                    end else begin
                        load_byte = PREAMBLE_BYTE;
                        pre_cnt_d = pre_cnt_q + PRE_CNT_W'(1);
                    end
                end
            end
            S_SFD: begin
                if (last_c) begin
                    load      = 1'b1;
                    load_byte = len_q;
                    state_d   = S_LEN;
`ifdef TX_FRAME_CRC8_EN
                    crc_d     = crc8_byte(8'h00, len_q);
`endif
                end
            end
            S_LEN, S_PAY: begin
                if (last_c) begin
                    if ((state_q == S_PAY) && (pay_cnt_q == 8'd0)) begin
`ifdef TX_FRAME_CRC8_EN
                        load      = 1'b1;
                        load_byte = crc_q;
                        state_d   = S_CRC;
`else
                        state_d   = S_IDLE;
                        done_d    = 1'b1;
`endif
                    end else if (byte_valid) begin
                        load       = 1'b1;
                        load_byte  = byte_in;
                        byte_ready = 1'b1;
                        state_d    = S_PAY;
                        // pay_cnt holds payload bytes still to fetch after this one
                        pay_cnt_d  = ((state_q == S_LEN) ? len_q : pay_cnt_q) - 8'd1;
`ifdef TX_FRAME_CRC8_EN
                        crc_d      = crc8_byte(crc_q, byte_in);
`endif
                    end else begin
                        underrun_d = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
            end
`ifdef TX_FRAME_CRC8_EN
            S_CRC: begin
                if (last_c) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_q     <= '0;
            pre_cnt_q <= '0;
            pay_cnt_q <= '0;
            to_lvds   <= 2'b00;
            busy      <= 1'b0;
            done      <= 1'b0;
            underrun  <= 1'b0;
`ifdef TX_FRAME_CRC8_EN
            crc_q     <= '0;
`endif
        end else begin
            len_q     <= len_d;
            pre_cnt_q <= pre_cnt_d;
            pay_cnt_q <= pay_cnt_d;
            busy      <= (state_d != S_IDLE);
            done      <= done_d;
            underrun  <= underrun_d;
`ifdef TX_FRAME_CRC8_EN
            crc_q     <= crc_d;
`endif
            if (sym_en) to_lvds <= active ? dibit_c : 2'b00;
        end
    end

endmodule

// File: tb/tb_tx_frame_serializer.sv
// Directed self-checking bench for tx_frame_serializer; expected CRC
// bytes are hand-computed and selected with TX_FRAME_CRC8_EN.
module tb_tx_frame_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic       sym_en;
    logic       start;
    logic [7:0] tx_len;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;
    logic [1:0] to_lvds;
    logic       busy;
    logic       done;
    logic       underrun;

    tx_frame_serializer dut (
        .clk        (clk),
        .reset      (reset),
        .sym_en     (sym_en),
        .start      (start),
        .tx_len     (tx_len),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .to_lvds    (to_lvds),
        .busy       (busy),
        .done       (done),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    // Show-ahead FIFO model
    logic [7:0] fifo_mem [16];
    int         rd = 0;
    int         wr = 0;
    int         pop_cnt = 0;
    assign byte_valid = (wr != rd);
    assign byte_in    = fifo_mem[rd[3:0]];
    always @(posedge clk) begin
        if (byte_ready) begin
            rd      <= rd + 1;
            pop_cnt <= pop_cnt + 1;
        end
    end

    int         checks = 0;
    int         errors = 0;
    logic [1:0] got [$];
    logic [7:0] exp_b [$];
    int         n_done, n_pops, hold_viol, timed_out;
    logic       busy_first, ur_first;

    task automatic chk(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo_mem[wr[3:0]] = b;
        wr = wr + 1;
    endtask

    task automatic set_exp(input logic [7:0] l);
        exp_b.delete();
        repeat (4) exp_b.push_back(8'h55);
        exp_b.push_back(8'hD5);
        exp_b.push_back(l);
    endtask

    task automatic cmp_frame(input string tag);
        int mism;
        logic [7:0] b;
        logic [1:0] d;
        mism = 0;
        chk({tag, "_ndibits"}, got.size(), 4 * exp_b.size());
        for (int i = 0; i < got.size(); i++) begin
            if (i / 4 < exp_b.size()) begin
                b = exp_b[i / 4];
                d = 2'(b >> (6 - 2 * (i % 4)));
                if (got[i] !== d) mism++;
            end
        end
        chk({tag, "_dibit_mismatches"}, mism, 0);
    endtask

    // Starts a frame and records every dibit emitted until busy falls.
    task automatic run(input logic [7:0] len, input int period, input int mid_start);
        int         c;
        int         pops0;
        bit         started;
        logic       bp;
        logic [1:0] prev;
        got.delete();
        n_done = 0; hold_viol = 0; timed_out = 0;
        busy_first = 1'b0; ur_first = 1'b1;
        pops0 = pop_cnt;
        c = 0; started = 0;
        tx_len = len;
        start  = 1'b1;
        while (1) begin
            sym_en = ((c % period) == 0);
            if (c == mid_start) begin
                start  = 1'b1;
                tx_len = 8'd7;
            end
            #1;
            bp   = busy;
            prev = to_lvds;
            @(posedge clk);
            #1;
            start = 1'b0;
            if (sym_en && bp) got.push_back(to_lvds);
            if (!sym_en && (to_lvds !== prev)) hold_viol++;
            if (done) n_done++;
            if (c == 0) begin
                busy_first = busy;
                ur_first   = underrun;
            end
            if (busy) started = 1;
            c++;
            if (started && !busy) break;
            if (c >= 2000) begin
                timed_out = 1;
                break;
            end
        end
        sym_en = 1'b0;
        n_pops = pop_cnt - pops0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int   pops0;
        int   cyc;
        bit   busy_seen;
        bit   lvds_seen;
        reset = 1'b1; sym_en = 1'b0; start = 1'b0; tx_len = 8'd0;
        step(2);

        // Reset values
        chk("rst_to_lvds", int'(to_lvds), 0);
        chk("rst_byte_ready", int'(byte_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_underrun", int'(underrun), 0);
        reset = 1'b0;
        step(1);

        // Frame A: one payload byte 0xA5, strobe every cycle
        push(8'hA5);
        run(8'd1, 1, -1);
        set_exp(8'h01); exp_b.push_back(8'hA5);
`ifdef TX_FRAME_CRC8_EN
        exp_b.push_back(8'h67);
`endif
        cmp_frame("frameA");
        chk("frameA_timeout", timed_out, 0);
        chk("frameA_pops", n_pops, 1);
        chk("frameA_done", n_done, 1);
        chk("frameA_busy_first", int'(busy_first), 1);
        chk("frameA_underrun", int'(underrun), 0);
        step(1);
        chk("frameA_done_cleared", int'(done), 0);

        // Frame B: zero payload byte; CRC-8 gives 0x15
        push(8'h00);
        run(8'd1, 1, -1);
        set_exp(8'h01); exp_b.push_back(8'h00);
`ifdef TX_FRAME_CRC8_EN
        exp_b.push_back(8'h15);
`endif
        cmp_frame("frameB");
        chk("frameB_done", n_done, 1);

        // Frame C: two bytes, start pulsed mid-frame must be ignored
        push(8'h12); push(8'h34);
        run(8'd2, 1, 30);
        set_exp(8'h02); exp_b.push_back(8'h12); exp_b.push_back(8'h34);
`ifdef TX_FRAME_CRC8_EN
        exp_b.push_back(8'h27);
`endif
        cmp_frame("frameC");
        chk("frameC_pops", n_pops, 2);
        chk("frameC_done", n_done, 1);
        step(3);
        chk("frameC_idle_after", int'(busy), 0);

        // Frame A again with strobe every 4th cycle
        push(8'hA5);
        run(8'd1, 4, -1);
        set_exp(8'h01); exp_b.push_back(8'hA5);
`ifdef TX_FRAME_CRC8_EN
        exp_b.push_back(8'h67);
`endif
        cmp_frame("slow");
        chk("slow_hold_viol", hold_viol, 0);
        chk("slow_done", n_done, 1);

        // start with tx_len=0 is ignored
        pops0 = pop_cnt;
        push(8'hEE);
        busy_seen = 0; lvds_seen = 0;
        sym_en = 1'b1; tx_len = 8'd0; start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1);
            start = 1'b0;
            if (busy) busy_seen = 1;
            if (to_lvds !== 2'b00) lvds_seen = 1;
        end
        sym_en = 1'b0;
        chk("len0_busy", int'(busy_seen), 0);
        chk("len0_lvds", int'(lvds_seen), 0);
        chk("len0_pops", pop_cnt - pops0, 0);
        wr = rd;

        // Underrun: tx_len=3 with one byte queued
        push(8'h77);
        run(8'd3, 1, -1);
        set_exp(8'h03); exp_b.push_back(8'h77);
        cmp_frame("urun");
        chk("urun_pops", n_pops, 1);
        chk("urun_flag", int'(underrun), 1);
        chk("urun_done", n_done, 0);
        chk("urun_busy", int'(busy), 0);
        sym_en = 1'b1;
        step(1);
        sym_en = 1'b0;
        chk("urun_lvds_zero", int'(to_lvds), 0);
        step(2);
        chk("urun_sticky", int'(underrun), 1);

        // Next accepted start clears underrun
        push(8'hA5);
        run(8'd1, 1, -1);
        chk("urun_cleared_on_start", int'(ur_first), 0);
        chk("urun_next_done", n_done, 1);

        // Reset mid-payload aborts with no done
        wr = rd;
        push(8'h3C); push(8'h81);
        pops0 = pop_cnt;
        sym_en = 1'b1; tx_len = 8'd2; start = 1'b1;
        cyc = 0;
        while ((pop_cnt - pops0) < 1 && cyc < 200) begin
            step(1);
            start = 1'b0;
            cyc++;
        end
        chk("rstmid_reached_payload", int'(cyc < 200), 1);
        step(2);
        chk("rstmid_busy_before", int'(busy), 1);
        reset = 1'b1;
        step(1);
        chk("rstmid_to_lvds", int'(to_lvds), 0);
        chk("rstmid_busy", int'(busy), 0);
        chk("rstmid_done", int'(done), 0);
        chk("rstmid_byte_ready", int'(byte_ready), 0);
        chk("rstmid_underrun", int'(underrun), 0);
        reset = 1'b0; sym_en = 1'b0;
        step(1);
        wr = rd;
        push(8'hA5);
        run(8'd1, 1, -1);
        set_exp(8'h01); exp_b.push_back(8'hA5);
`ifdef TX_FRAME_CRC8_EN
        exp_b.push_back(8'h67);
`endif
        cmp_frame("after_rst");
        chk("after_rst_done", n_done, 1);
        chk("after_rst_pops", n_pops, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_frame_serializer.md
Name: tx_frame_serializer

Overview:
- Frame builder and dibit serializer between the packet FIFO (byte source, written over SPI) and the 2-bit LVDS transmit lane.
- On a start command it emits a frame as MSB-first dibits, one dibit per symbol strobe: preamble, SFD, length byte, payload, and optionally a CRC-8.
- Exposes busy/done/underrun status for the status register.

Parameters:
- PREAMBLE_BYTES, 4, number of preamble bytes (1..15).
- PREAMBLE_BYTE, 8'h55, preamble byte value.
- SFD_BYTE, 8'hD5, start-of-frame delimiter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sym_en  in  1  symbol-rate strobe; one dibit advances per asserted cycle.
- start  in  1  single-cycle frame start command.
- tx_len  in  8  payload length in bytes; sampled when start is accepted.
- byte_in  in  8  FIFO head byte (show-ahead).
- byte_valid  in  1  FIFO not empty.
- byte_ready  out  1  one-cycle pop of the FIFO head.
- to_lvds  out  2  registered dibit to the LVDS lane.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse when a frame completes normally.
- underrun  out  1  sticky flag: FIFO empty when a payload byte was needed.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: to_lvds=2'b00, byte_ready=0, busy=0, done=0, underrun=0. State=IDLE; shifter, counters and CRC cleared. A reset mid-frame aborts the frame immediately, with no done pulse.
- States: IDLE, PRE, SFD, LEN, PAY, CRC (CRC only with the feature enabled).
- Start acceptance:
  - start is accepted only in IDLE with tx_len!=0.
  - Otherwise start is ignored, including while busy.
  - On acceptance: latch tx_len, clear underrun, load the shifter with PREAMBLE_BYTE, set byte counter=0, dibit counter=0, busy=1 the next cycle.
- Serialization:
  - On each sym_en in a non-IDLE state: to_lvds <= shifter[7:6], shifter <<= 2, dibit counter++.
  - to_lvds changes only on sym_en cycles.
  - In IDLE, each sym_en drives to_lvds <= 2'b00.
- Byte boundary (dibit counter==3 and sym_en): load the next byte in the same cycle.
  - PRE → next PREAMBLE_BYTE until PREAMBLE_BYTES are sent, then SFD_BYTE.
  - SFD → the latched length.
  - LEN → first payload byte.
  - PAY → next payload byte, or CRC/end after the last one.
- Payload fetch:
  - At a boundary that loads a payload byte, byte_ready=1 for exactly that cycle when byte_valid=1, and byte_in is loaded.
  - If byte_valid=0: set underrun=1, byte_ready=0, go to IDLE, deassert busy, no done pulse. The next sym_en drives to_lvds=00.
- Completion:
  - After the final dibit of the last byte is driven, the state goes to IDLE and busy=0.
  - done=1 in the same cycle the last dibit is driven (last-byte boundary sym_en).
  - A start in that same cycle is ignored; a start is accepted from the following cycle.
- Payload count: an 8-bit down-counter; tx_len=255 is supported with no wrap.
- Never more than tx_len pops per frame.
- Total dibits per frame: 4×(PREAMBLE_BYTES+2+tx_len[+1]).

Optional Feature:
- Macro: TX_FRAME_CRC8_EN.
- Defined:
  - CRC-8, polynomial 0x07, init 0x00, no reflection, no final XOR.
  - Computed over the length byte and the payload bytes, updated as each byte is loaded into the shifter.
  - The CRC byte is appended after the payload in state CRC.
- Undefined: no CRC state or logic; the frame ends after the last payload byte.

Decomposition:
- Package tx_frame_pkg holds:
  - the state enum typedef;
  - CRC8_POLY=8'h07;
  - the default preamble/SFD constants;
  - the crc8_byte() function.
- One natural sub-module: dibit_shifter (8-bit load/shift with dibit counter and boundary flag, gated by sym_en).

Test Plan:
- sym_en every cycle, PREAMBLE_BYTES=4, tx_len=1, FIFO holds 0xA5 → to_lvds sequence: 16×01; SFD 11,01,01,01; length 00,00,00,01; payload 10,10,01,01. byte_ready pulses once; done pulses once; busy spans the frame.
- tx_len=1, payload 0x00, TX_FRAME_CRC8_EN defined → trailing CRC byte 0x15 = 00,01,01,01. Undefined → frame ends after payload, with 4 fewer dibits.
- tx_len=3, FIFO holds 1 byte → one byte_ready, underrun=1 at the second payload boundary, busy drops, no done, to_lvds=00. underrun clears on the next accepted start.
- start with tx_len=0 → ignored: busy stays 0, no output activity. start pulsed while busy → no effect on the frame in progress.
- sym_en every 4th cycle → to_lvds changes only on strobe cycles; dibit sequence identical to the first scenario.
- reset asserted mid-payload → next cycle all outputs at reset values, no done. A subsequent start produces a clean full frame.
